// File: rtl/fnd_pkg.sv
// ============================================================================
//  Module      : fnd_pkg
//  Description : Shared types, widths and the display clamp helper for the
//                FND display arbiter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package fnd_pkg;

    localparam int DISP_W = 14;
    localparam int SEL_W  = 2;

    localparam logic [DISP_W-1:0] MAX_DISP = 14'd9999;

    typedef enum logic [0:0] {
        SHOW_A = 1'b0,
        SHOW_B = 1'b1
    } arb_state_e;

    // Four BCD digits cannot show more than 9999; saturate instead of wrapping.
    function automatic logic [DISP_W-1:0] clamp_disp(input logic [DISP_W-1:0] x);
        return (x > MAX_DISP) ? MAX_DISP : x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_tick_gen.sv
// ============================================================================
//  Module      : scan_tick_gen
//  Description : Digit-scan divider producing a one-cycle tick every SCAN_DIV
//                clocks and a 2-bit digit select that advances on each tick.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module scan_tick_gen
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [SEL_W-1:0] sel
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(SCAN_DIV - 2);

    logic [CNT_W-1:0] div_cnt;

    // tick is registered one count early so it is high exactly while
    // div_cnt sits at its terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
            sel     <= '0;
        end else begin
            if (div_cnt == CNT_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            tick <= (div_cnt == CNT_PRE_LAST);
            if (tick) begin
                sel <= sel + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fnd_disp_arbiter.sv
// ============================================================================
//  Module      : fnd_disp_arbiter
//  Description : Scan sequencer and A/B display arbiter; B messages pre-empt
//                the background value for HOLD_TICKS scan ticks.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fnd_disp_arbiter
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV   = 100_000,
    parameter int HOLD_TICKS = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DISP_W-1:0] a_value,
    input  logic              b_valid,
    input  logic [DISP_W-1:0] b_value,
    output logic              tick,
    output logic [SEL_W-1:0]  sel,
    output logic [DISP_W-1:0] disp_value,
    output logic              disp_src,
    output logic              b_active
);

    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(3);

    arb_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt, hold_d;
    logic [DISP_W-1:0] b_val_q, b_val_d;
    logic              fb;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .sel  (sel)
    );

    assign fb       = tick && (sel == SEL_LAST);
    assign b_active = (state_q == SHOW_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SHOW_A;
            hold_cnt <= '0;
            b_val_q  <= '0;
        end else begin
            state_q  <= state_d;
            hold_cnt <= hold_d;
            b_val_q  <= b_val_d;
        end
    end

    // A new message always wins over an expiring tick on the same edge.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_cnt;
        b_val_d = b_val_q;
        case (state_q)
            SHOW_A: begin
                if (b_valid) begin
                    state_d = SHOW_B;
                    hold_d  = HOLD_INIT;
                    b_val_d = b_value;
                end
            end
            SHOW_B: begin
                if (b_valid) begin
                    hold_d  = HOLD_INIT;
                    b_val_d = b_value;
                end else if (tick) begin
                    if (hold_cnt == HOLD_ONE) begin
                        state_d = SHOW_A;
                        hold_d  = '0;
                    end else begin
                        hold_d  = hold_cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_d = SHOW_A;
                hold_d  = '0;
            end
        endcase
    end

    // Display value only moves on frame boundaries so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_value <= '0;
            disp_src   <= 1'b0;
        end else if (fb) begin
            disp_value <= clamp_disp((state_q == SHOW_B) ? b_val_q : a_value);
            disp_src   <= (state_q == SHOW_B);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fnd_disp_arbiter.sv
// ============================================================================
//  Module      : tb_fnd_disp_arbiter
//  Description : Directed self-checking bench for fnd_disp_arbiter with
//                SCAN_DIV=4, HOLD_TICKS=8 (frame boundary every 16 cycles).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fnd_disp_arbiter;

    logic        clk;
    logic        rst;
    logic [13:0] a_value;
    logic        b_valid;
    logic [13:0] b_value;
    logic        tick;
    logic [1:0]  sel;
    logic [13:0] disp_value;
    logic        disp_src;
    logic        b_active;

    int vec_cnt;
    int err_cnt;
    int cyc;

    fnd_disp_arbiter #(
        .SCAN_DIV   (4),
        .HOLD_TICKS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_value    (a_value),
        .b_valid    (b_valid),
        .b_value    (b_value),
        .tick       (tick),
        .sel        (sel),
        .disp_value (disp_value),
        .disp_src   (disp_src),
        .b_active   (b_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Outputs are sampled on the falling edge, midway between active edges.
    task automatic next_cyc();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) next_cyc();
    endtask

    task automatic check_disp(input string tag, input int v, input int src);
        check_val({tag, "_val"}, 32'(disp_value), v);
        check_val({tag, "_src"}, 32'(disp_src), src);
    endtask

    task automatic pulse_b(input int v);
        b_valid = 1'b1;
        b_value = 14'(v);
        next_cyc();
        b_valid = 1'b0;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        cyc     = 0;
        rst     = 1'b1;
        a_value = 14'd1234;
        b_valid = 1'b0;
        b_value = '0;

        repeat (2) @(negedge clk);
        check_val("rst_tick", 32'(tick), 0);
        check_val("rst_sel", 32'(sel), 0);
        check_val("rst_bact", 32'(b_active), 0);
        check_disp("rst_disp", 0, 0);
        rst = 1'b0;
        cyc = 0;

        // Scan cadence and first frame boundary at cycle 16
        for (int c = 1; c <= 16; c++) begin
            next_cyc();
            check_val("scan_tick", 32'(tick), (c % 4 == 3) ? 1 : 0);
            check_val("scan_sel", 32'(sel), (c / 4) % 4);
            check_disp("first_fb", (c >= 16) ? 1234 : 0, 0);
        end

        // Clamp and mid-frame changes of A
        a_value = 14'd12000;
        run_to(31); check_disp("pre_clamp", 1234, 0);
        run_to(32); check_disp("clamp_a", 9999, 0);
        a_value = 14'd5;
        run_to(48); check_disp("a_five", 5, 0);
        run_to(52); a_value = 14'd6;
        run_to(63); check_disp("a_midframe", 5, 0);
        run_to(64); check_disp("a_six", 6, 0);

        // Basic B message, 8-tick hold
        run_to(66); check_val("b_idle", 32'(b_active), 0);
        pulse_b(42);
        check_val("b_rise", 32'(b_active), 1);
        run_to(79); check_disp("b_pre_fb", 6, 0);
        run_to(80); check_disp("b_show", 42, 1);
        run_to(95); check_val("b_hold_end", 32'(b_active), 1);
        run_to(96); check_val("b_fall", 32'(b_active), 0);
        check_disp("b_fall_fb", 42, 1);
        run_to(112); check_disp("back_to_a", 6, 0);

        // Retrigger after 6 ticks of hold
        run_to(114); pulse_b(11);
        run_to(128); check_disp("rt_first", 11, 1);
        run_to(137); pulse_b(77);
        run_to(143); check_disp("rt_pre", 11, 1);
        run_to(144); check_disp("rt_new", 77, 1);
        check_val("rt_extended", 32'(b_active), 1);
        run_to(167); check_val("rt_hold_end", 32'(b_active), 1);
        run_to(168); check_val("rt_fall", 32'(b_active), 0);

        // b_valid coincident with the expiring 8th tick
        run_to(169); pulse_b(300);
        run_to(176); check_disp("co_show", 300, 1);
        run_to(199); check_val("co_pre", 32'(b_active), 1);
        pulse_b(555);
        check_val("co_stay", 32'(b_active), 1);
        run_to(208); check_disp("co_new", 555, 1);
        run_to(231); check_val("co_hold_end", 32'(b_active), 1);
        run_to(232); check_val("co_fall", 32'(b_active), 0);

        // b_valid on a frame-boundary edge; B value also clamps
        run_to(239); pulse_b(16383);
        check_disp("fbb_old", 6, 0);
        check_val("fbb_bact", 32'(b_active), 1);
        run_to(255); check_disp("fbb_hold", 6, 0);
        run_to(256); check_disp("fbb_clamp_b", 9999, 1);

        // Asynchronous reset mid-hold and mid-frame
        run_to(263);
        check_val("pre_rst_tick", 32'(tick), 1);
        check_val("pre_rst_sel", 32'(sel), 1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_tick", 32'(tick), 0);
        check_val("arst_sel", 32'(sel), 0);
        check_val("arst_bact", 32'(b_active), 0);
        check_disp("arst_disp", 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 5; c++) begin
            next_cyc();
            check_val("post_rst_tick", 32'(tick), (c == 3) ? 1 : 0);
            check_val("post_rst_sel", 32'(sel), (c >= 4) ? 1 : 0);
            check_val("post_rst_bact", 32'(b_active), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
